// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined ALU shifter: mode encodings and the
// helper that derives the number of logarithmic shift stages from the width.
package shift_pkg;

   localparam logic [1:0] MODE_SRL = 2'b00;
   localparam logic [1:0] MODE_SLL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   // One stage per bit of the shift amount; never fewer than one stage.
   function automatic int stage_count(input int width);
      int n;
      n = $clog2(width);
      if (n < 1) n = 1;
      return n;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional shift/rotate step of the logarithmic shifter. The word
// carries a guard bit: bit 0 for right shifts, bit WIDTH for left shifts.
// Rotates act only on the low WIDTH bits and leave the guard bit untouched.
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DIST  = 1
) (
   input  logic [WIDTH:0] word_i,
   input  logic [1:0]     mode_i,
   input  logic           en_i,
   output logic [WIDTH:0] word_o
);

   logic fill;

   // Shift or rotate the guarded word by DIST when enabled, else pass through.
   always_comb begin
      fill   = (mode_i == MODE_SRA) ? word_i[WIDTH] : 1'b0;
      word_o = word_i;
      if (en_i) begin
         unique case (mode_i)
            MODE_SRL, MODE_SRA: word_o = {{DIST{fill}}, word_i[WIDTH:DIST]};
            MODE_SLL:           word_o = {word_i[WIDTH-DIST:0], {DIST{1'b0}}};
            default:            word_o = {word_i[WIDTH], word_i[DIST-1:0], word_i[WIDTH-1:DIST]};
         endcase
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Pipelined WIDTH-bit shifter (SRL/SLL/SRA/ROR) with carry and zero flags.
// A valid/ready handshake stalls the whole pipe when the output is held.
// PIPE=1 registers after every stage; PIPE=0 keeps only the output register.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int SHW   = stage_count(WIDTH),
   parameter int PIPE  = 1,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   // Carry is forced to 0 when every bit has been shifted away (SRL/SLL with
   // amt >= WIDTH) and when a rotate is a whole number of turns.
   function automatic logic carry_kill(input logic [1:0] mode, input logic [SHW-1:0] amt);
      logic kill;
      kill = 1'b0;
      case (mode)
         MODE_SRL, MODE_SLL: kill = (32'(amt) >= 32'(WIDTH));
         MODE_ROR:           kill = (amt == '0) || (32'(amt) == 32'(WIDTH));
         default:            kill = 1'b0;
      endcase
      return kill;
   endfunction

   // Pull {carry, result} out of the final guarded word.
   function automatic logic [WIDTH:0] extract(input logic [WIDTH:0] w, input logic [1:0] mode,
                                              input logic kill);
      logic [WIDTH-1:0] res;
      logic             car;
      case (mode)
         MODE_SRL, MODE_SRA: begin res = w[WIDTH:1];   car = w[0];       end
         MODE_SLL:           begin res = w[WIDTH-1:0]; car = w[WIDTH];   end
         default:            begin res = w[WIDTH-1:0]; car = w[WIDTH-1]; end
      endcase
      if (kill) car = 1'b0;
      return {car, res};
   endfunction

   logic adv;

   logic [WIDTH:0]   stg_word [SHW];
   logic [1:0]       stg_mode [SHW];
   logic [SHW-1:0]   stg_amt  [SHW];
   logic [TAG_W-1:0] stg_tag  [SHW];
   logic             stg_cz   [SHW];
   logic             stg_vld  [SHW];
   logic [WIDTH:0]   sh_word  [SHW];

   logic [WIDTH:0]   word_q [SHW], word_d [SHW];
   logic [1:0]       mode_q [SHW], mode_d [SHW];
   logic [SHW-1:0]   amt_q  [SHW], amt_d  [SHW];
   logic [TAG_W-1:0] tag_q  [SHW], tag_d  [SHW];
   logic             cz_q   [SHW], cz_d   [SHW];
   logic             vld_q  [SHW], vld_d  [SHW];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_carry_q, out_carry_d;
   logic             out_zero_q, out_zero_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [WIDTH:0]   fin;

   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   // Stage inputs: stage 0 takes the guarded operand, later stages take the
   // previous stage's register (PIPE=1) or its combinational output (PIPE=0).
   always_comb begin
      stg_word[0] = (in_mode == MODE_SRL || in_mode == MODE_SRA) ? {in_data, 1'b0}
                                                                 : {1'b0, in_data};
      stg_mode[0] = in_mode;
      stg_amt[0]  = in_amt;
      stg_tag[0]  = in_tag;
      stg_cz[0]   = carry_kill(in_mode, in_amt);
      stg_vld[0]  = in_valid;
      for (int i = 1; i < SHW; i++) begin
         if (PIPE != 0) begin
            stg_word[i] = word_q[i-1];
            stg_mode[i] = mode_q[i-1];
            stg_amt[i]  = amt_q[i-1];
            stg_tag[i]  = tag_q[i-1];
            stg_cz[i]   = cz_q[i-1];
            stg_vld[i]  = vld_q[i-1];
         end else begin
            stg_word[i] = sh_word[i-1];
            stg_mode[i] = stg_mode[i-1];
            stg_amt[i]  = stg_amt[i-1];
            stg_tag[i]  = stg_tag[i-1];
            stg_cz[i]   = stg_cz[i-1];
            stg_vld[i]  = stg_vld[i-1];
         end
      end
   end

   for (genvar g = 0; g < SHW; g++) begin : g_stage
      shift_stage #(.WIDTH(WIDTH), .DIST(1 << g)) u_stage (
         .word_i (stg_word[g]),
         .mode_i (stg_mode[g]),
         .en_i   (stg_amt[g][g]),
         .word_o (sh_word[g])
      );
   end

   // Stage registers advance together and hold as a block during a stall.
   always_comb begin
      for (int i = 0; i < SHW; i++) begin
         word_d[i] = word_q[i];
         mode_d[i] = mode_q[i];
         amt_d[i]  = amt_q[i];
         tag_d[i]  = tag_q[i];
         cz_d[i]   = cz_q[i];
         vld_d[i]  = vld_q[i];
         if (adv) begin
            word_d[i] = sh_word[i];
            mode_d[i] = stg_mode[i];
            amt_d[i]  = stg_amt[i];
            tag_d[i]  = stg_tag[i];
            cz_d[i]   = stg_cz[i];
            vld_d[i]  = stg_vld[i];
         end
      end
   end

   // Stage boundary registers; only the valid bits need a reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SHW; i++) begin
         word_q[i] <= word_d[i];
         mode_q[i] <= mode_d[i];
         amt_q[i]  <= amt_d[i];
         tag_q[i]  <= tag_d[i];
         cz_q[i]   <= cz_d[i];
         vld_q[i]  <= rst ? 1'b0 : vld_d[i];
      end
   end

   assign fin = extract(sh_word[SHW-1], stg_mode[SHW-1], stg_cz[SHW-1]);

   // Output register: result fields load only with a valid operation.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      out_zero_d  = out_zero_q;
      out_tag_d   = out_tag_q;
      if (adv) begin
         out_valid_d = stg_vld[SHW-1];
         if (stg_vld[SHW-1]) begin
            out_data_d  = fin[WIDTH-1:0];
            out_carry_d = fin[WIDTH];
            out_zero_d  = (fin[WIDTH-1:0] == '0);
            out_tag_d   = stg_tag[SHW-1];
         end
      end
   end

   // Output state with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_zero_q  <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
         out_zero_q  <= out_zero_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_zero  = out_zero_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit (WIDTH=12, PIPE=1): directed cases, a randomized
// stream under random backpressure, and a mid-flight reset.
module tb_shift_unit;

   localparam int WIDTH = 12;
   localparam int SHW   = 4;
   localparam int PIPE  = 1;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [SHW-1:0]   in_amt = '0;
   logic [1:0]       in_mode = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   always #5 clk = ~clk;

   shift_unit #(.WIDTH(WIDTH), .SHW(SHW), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_zero  (out_zero),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             carry;
      logic             zero;
      logic [TAG_W-1:0] tag;
      int               acc;
      bit               lat;
   } exp_t;

   exp_t             q[$];
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   bit               rand_rdy = 1'b0;
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] held_data = '0;
   logic [TAG_W-1:0] held_tag = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Reference: {carry, result} from the shift rules with plain arithmetic.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int a,
                                            input logic [1:0] m);
      logic [WIDTH-1:0] r;
      logic             c;
      int               k;
      r = d;
      c = 1'b0;
      if (a != 0) begin
         case (m)
            2'b00: if (a >= WIDTH) begin r = '0; c = 1'b0; end
                   else begin r = d >> a; c = d[a-1]; end
            2'b01: if (a >= WIDTH) begin r = '0; c = 1'b0; end
                   else begin r = d << a; c = d[WIDTH-a]; end
            2'b10: if (a >= WIDTH) begin r = {WIDTH{d[WIDTH-1]}}; c = d[WIDTH-1]; end
                   else begin r = WIDTH'($signed(d) >>> a); c = d[a-1]; end
            default: begin
               k = a % WIDTH;
               if (k != 0) begin
                  r = (d >> k) | (d << (WIDTH - k));
                  c = r[WIDTH-1];
               end
            end
         endcase
      end
      return {c, r};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: handshake rule, hold-while-stalled, in-order scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      logic adv_exp;
      adv_exp = ~out_valid | out_ready;
      check("in_ready", 32'(in_ready), 32'(adv_exp));
      if (!rst) begin
         if (stall_prev) begin
            check("hold_vld", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_tag", 32'(out_tag), 32'(held_tag));
         end
         stall_prev = out_valid & ~out_ready;
         held_data  = out_data;
         held_tag   = out_tag;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("extra_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("data", 32'(out_data), 32'(e.data));
               check("carry", 32'(out_carry), 32'(e.carry));
               check("zero", 32'(out_zero), 32'(e.zero));
               check("tag", 32'(out_tag), 32'(e.tag));
               // edges from the accepting edge through the one that raised out_valid
               if (e.lat) check("latency", 32'(cyc - e.acc + 1), 32'(SHW));
            end
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                       input logic [1:0] m, input logic [TAG_W-1:0] t, input bit lat);
      int            waitc;
      exp_t          e;
      logic [WIDTH:0] r;
      waitc    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      in_tag   = t;
      @(negedge clk);
      while (!in_ready && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         check("send_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         r       = model(d, int'(a), m);
         e.data  = r[WIDTH-1:0];
         e.carry = r[WIDTH];
         e.zero  = (r[WIDTH-1:0] == '0);
         e.tag   = t;
         e.acc   = cyc;
         e.lat   = lat;
         q.push_back(e);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_clear(input string pfx);
      check({pfx, "_valid"}, 32'(out_valid), 32'd0);
      check({pfx, "_data"}, 32'(out_data), 32'd0);
      check({pfx, "_carry"}, 32'(out_carry), 32'd0);
      check({pfx, "_zero"}, 32'(out_zero), 32'd0);
      check({pfx, "_tag"}, 32'(out_tag), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_outputs_clear("rst");
      rst = 1'b0;

      send(12'hABC, 4'd4,  2'b00, 4'h1, 1'b1);
      send(12'h800, 4'd3,  2'b10, 4'h2, 1'b1);
      send(12'h800, 4'd15, 2'b10, 4'h3, 1'b1);
      send(12'h801, 4'd1,  2'b01, 4'h4, 1'b1);
      send(12'hFFF, 4'd12, 2'b01, 4'h5, 1'b1);
      send(12'h001, 4'd13, 2'b11, 4'h6, 1'b1);
      send(12'h5A5, 4'd0,  2'b11, 4'h7, 1'b1);
      send(12'hFFF, 4'd12, 2'b00, 4'h8, 1'b1);
      send(12'h9C3, 4'd12, 2'b11, 4'h9, 1'b1);
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(12'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              4'(i % 16), 1'b0);
      end
      rand_rdy = 1'b0;
      drain();

      send(12'h123, 4'd5, 2'b00, 4'hA, 1'b0);
      send(12'h456, 4'd7, 2'b01, 4'hB, 1'b0);
      send(12'h789, 4'd9, 2'b10, 4'hC, 1'b0);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs_clear("midrst");
      send(12'h5A5, 4'd3, 2'b11, 4'hD, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
